// File: rtl/decod_param_reg.sv
// Registered N-to-2**N one-hot decoder with valid/ready input handshake.
// Define DECOD_SWEEP_EN to build the walking-one sweep mode (VARREDURA state).
module decod_param_reg #(
    parameter int N   = 3,
    parameter int DIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            modo,
    input  logic            entrada_valida,
    input  logic [N-1:0]    entrada,
    output logic            entrada_pronta,
    output logic [2**N-1:0] saida,
    output logic            saida_valida,
    output logic [N-1:0]    indice,
    output logic            fim_ciclo
);

    localparam int W = 2**N;

`ifdef DECOD_SWEEP_EN
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        DIRETO    = 2'd1,
        VARREDURA = 2'd2
    } estado_t;

    logic [CW-1:0] cnt, nxt_cnt;
    logic          fim_r, nxt_fim;
`else
    typedef enum logic [0:0] {
        OCIOSO = 1'b0,
        DIRETO = 1'b1
    } estado_t;

    logic unused_cfg;
    assign unused_cfg = modo & (DIV > 0);
`endif

    estado_t       state, nxt_state;
    logic [W-1:0]  nxt_saida;
    logic          nxt_valida;
    logic [N-1:0]  nxt_indice;
    logic          transfer;

`ifdef DECOD_SWEEP_EN
    assign entrada_pronta = en && (state != VARREDURA) && !modo;
    assign fim_ciclo      = fim_r;
`else
    assign entrada_pronta = en;
    assign fim_ciclo      = 1'b0;
`endif

    assign transfer = entrada_valida && entrada_pronta;

    always_comb begin
        nxt_state  = state;
        nxt_saida  = saida;
        nxt_valida = saida_valida;
        nxt_indice = indice;
`ifdef DECOD_SWEEP_EN
        nxt_cnt    = cnt;
        nxt_fim    = 1'b0;
`endif
        if (!en) begin
            // Disable always parks in OCIOSO; indice keeps its last value.
            nxt_state  = OCIOSO;
            nxt_saida  = '0;
            nxt_valida = 1'b0;
        end else begin
            case (state)
`ifdef DECOD_SWEEP_EN
                VARREDURA: begin
                    if (!modo) begin
                        nxt_state  = OCIOSO;
                        nxt_saida  = '0;
                        nxt_valida = 1'b0;
                    end else if (cnt == CW'(DIV - 1)) begin
                        nxt_cnt    = '0;
                        nxt_indice = indice + 1'b1;
                        nxt_saida  = W'(1) << nxt_indice;
                        nxt_fim    = (nxt_indice == '0);
                    end else begin
                        nxt_cnt = cnt + 1'b1;
                    end
                end
`endif
                default: begin
`ifdef DECOD_SWEEP_EN
                    if (modo) begin
                        nxt_state  = VARREDURA;
                        nxt_indice = '0;
                        nxt_saida  = W'(1);
                        nxt_valida = 1'b1;
                        nxt_cnt    = '0;
                    end else
`endif
                    if (transfer) begin
                        nxt_state  = DIRETO;
                        nxt_saida  = W'(1) << entrada;
                        nxt_indice = entrada;
                        nxt_valida = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= OCIOSO;
            saida        <= '0;
            saida_valida <= 1'b0;
            indice       <= '0;
`ifdef DECOD_SWEEP_EN
            cnt          <= '0;
            fim_r        <= 1'b0;
`endif
        end else begin
            state        <= nxt_state;
            saida        <= nxt_saida;
            saida_valida <= nxt_valida;
            indice       <= nxt_indice;
`ifdef DECOD_SWEEP_EN
            cnt          <= nxt_cnt;
            fim_r        <= nxt_fim;
`endif
        end
    end

endmodule

// File: tb/tb_decod_param_reg.sv
// Directed self-checking bench for decod_param_reg; sweep instances are built
// only when DECOD_SWEEP_EN is defined.
module tb_decod_param_reg;

    int n_checks = 0;
    int n_fail   = 0;

    logic       clk = 1'b0;
    logic       rst, en, modo, valid;
    logic [2:0] entrada;
    logic       pronta, saida_valida, fim;
    logic [7:0] saida;
    logic [2:0] indice;

    always #5 clk = ~clk;

    decod_param_reg #(.N(3), .DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .modo(modo),
        .entrada_valida(valid), .entrada(entrada),
        .entrada_pronta(pronta), .saida(saida), .saida_valida(saida_valida),
        .indice(indice), .fim_ciclo(fim)
    );

`ifdef DECOD_SWEEP_EN
    logic       rst2, en2, modo2, valid2;
    logic [1:0] entrada2;
    logic       pronta_s, sv_s, fim_s, pronta_1, sv_1, fim_1;
    logic [3:0] saida_s, saida_1;
    logic [1:0] idx_s, idx_1;

    decod_param_reg #(.N(2), .DIV(3)) dut_s (
        .clk(clk), .rst(rst2), .en(en2), .modo(modo2),
        .entrada_valida(valid2), .entrada(entrada2),
        .entrada_pronta(pronta_s), .saida(saida_s), .saida_valida(sv_s),
        .indice(idx_s), .fim_ciclo(fim_s)
    );

    decod_param_reg #(.N(2), .DIV(1)) dut_1 (
        .clk(clk), .rst(rst2), .en(en2), .modo(modo2),
        .entrada_valida(valid2), .entrada(entrada2),
        .entrada_pronta(pronta_1), .saida(saida_1), .saida_valida(sv_1),
        .indice(idx_1), .fim_ciclo(fim_1)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; modo = 1'b0; valid = 1'b0; entrada = '0;
`ifdef DECOD_SWEEP_EN
        rst2 = 1'b1; en2 = 1'b0; modo2 = 1'b0; valid2 = 1'b0; entrada2 = '0;
`endif
        tick(); tick();
        check("rst_saida", saida, 8'h00);
        check("rst_valid", saida_valida, 1'b0);
        check("rst_indice", indice, 3'd0);
        check("rst_fim", fim, 1'b0);
        rst = 1'b0;

        // Direct decode
        en = 1'b1;
        #1 check("pronta_en", pronta, 1'b1);
        entrada = 3'd5; valid = 1'b1;
        tick();
        check("dec5_saida", saida, 8'h20);
        check("dec5_indice", indice, 3'd5);
        check("dec5_valid", saida_valida, 1'b1);
        valid = 1'b0; entrada = 3'd1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_saida", saida, 8'h20);
        end
        check("hold_indice", indice, 3'd5);

        valid = 1'b1; entrada = 3'd0;
        tick(); check("b2b0", saida, 8'h01);
        entrada = 3'd7;
        tick(); check("b2b7", saida, 8'h80);
        check("b2b7_idx", indice, 3'd7);
        entrada = 3'd3;
        tick(); check("b2b3", saida, 8'h08);
        entrada = 3'd5;
        tick(); check("dec5b", saida, 8'h20);
        valid = 1'b0;

        // Enable dropped
        en = 1'b0; valid = 1'b1; entrada = 3'd2;
        #1 check("pronta_dis", pronta, 1'b0);
        tick();
        check("dis_saida", saida, 8'h00);
        check("dis_valid", saida_valida, 1'b0);
        check("dis_indice", indice, 3'd5);
        check("dis_fim", fim, 1'b0);
        tick();
        check("dis_ignored", saida, 8'h00);
        en = 1'b1; valid = 1'b0;
        #1 check("pronta_reen", pronta, 1'b1);
        tick();
        check("reen_saida", saida, 8'h00);
        check("reen_valid", saida_valida, 1'b0);
        valid = 1'b1; entrada = 3'd2;
        tick();
        check("reen_dec2", saida, 8'h04);
        check("reen_valid2", saida_valida, 1'b1);
        valid = 1'b0;

`ifndef DECOD_SWEEP_EN
        // modo ignored when sweep is compiled out
        modo = 1'b1; entrada = 3'd6; valid = 1'b1;
        #1 check("nosweep_pronta", pronta, 1'b1);
        tick();
        check("nosweep_saida", saida, 8'h40);
        check("nosweep_fim", fim, 1'b0);
        valid = 1'b0;
        tick();
        check("nosweep_hold", saida, 8'h40);
        check("nosweep_fim2", fim, 1'b0);
`else
        // Sweep, N=2: dut_s DIV=3, dut_1 DIV=1
        rst2 = 1'b0; en2 = 1'b1; modo2 = 1'b1; valid2 = 1'b1;
        #1 check("sw_pronta0", pronta_s, 1'b0);
        tick();
        for (int k = 0; k < 19; k++) begin
            check("sw_saida", saida_s, 4'b0001 << ((k / 3) % 4));
            check("sw_fim", fim_s, (k == 12) ? 1'b1 : 1'b0);
            check("sw_pronta", pronta_s, 1'b0);
            check("sw_valid", sv_s, 1'b1);
            check("sw1_idx", idx_1, k % 4);
            check("sw1_fim", fim_1, (k % 4 == 0 && k > 0) ? 1'b1 : 1'b0);
            if (k < 18) tick();
        end
        check("sw_at2", idx_s, 2'd2);
        rst2 = 1'b1;
        tick();
        check("swrst_saida", saida_s, 4'b0000);
        check("swrst_valid", sv_s, 1'b0);
        check("swrst_idx", idx_s, 2'd0);
        check("swrst_fim", fim_s, 1'b0);
        check("swrst1_saida", saida_1, 4'b0000);
        rst2 = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            check("sw1r_saida", saida_1, 4'b0001 << (k % 4));
            check("sw1r_fim", fim_1, (k == 4) ? 1'b1 : 1'b0);
            check("swr_idx", idx_s, k / 3);
            tick();
        end
        modo2 = 1'b0;
        tick();
        check("swoff_saida", saida_s, 4'b0000);
        check("swoff_valid", sv_s, 1'b0);
        check("swoff1_saida", saida_1, 4'b0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
